// File: rtl/phase_delay_pkg.sv
// phase_delay_pkg: shared constants, edge-queue entry type and the
// effective-delay helper used by the phase delay line.
package phase_delay_pkg;

    localparam int N_CH_DEFAULT       = 4;
    localparam int WAIT_CNT_SIZE      = 11;
    localparam int EDGE_DEPTH_DEFAULT = 8;

    typedef logic [WAIT_CNT_SIZE-1:0] wait_t;

    // One pending output event: the timestamp it falls due and the level to drive.
    typedef struct packed {
        wait_t due;
        logic  level;
    } edge_entry_t;

    // A delay of zero is treated as one cycle so a freshly pushed entry is
    // never due on the same timestamp it was computed from.
    function automatic wait_t eff_delay(input wait_t d);
        return (d == '0) ? wait_t'(1) : d;
    endfunction

endpackage

// File: rtl/delay_edge_queue.sv
// delay_edge_queue: per-channel FIFO of timestamped edges. The head entry is
// popped on the cycle its due time matches the shared timestamp t. A push
// into a full queue is refused; the caller flags that as overflow.
module delay_edge_queue
    import phase_delay_pkg::*;
#(
    parameter int DEPTH = EDGE_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        flush,
    input  logic        push,
    input  edge_entry_t push_entry,
    input  wait_t       t,
    output logic        pop,
    output logic        head_level,
    output logic        full
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    edge_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          do_push;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_CNT);
    assign head_level = mem[rd_ptr].level;
    // Dues are monotonic between flushes, so only the head can be due.
    assign pop        = !flush && !empty && (mem[rd_ptr].due == t);
    assign do_push    = !flush && push && !full;

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; only slots below count are ever read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/phase_delay_multi.sv
// phase_delay_multi: N_CH-channel programmable delay line. Each input edge is
// queued with the timestamp it must reappear at, so delays may exceed the
// signal half-period. Build macro PHASE_DELAY_SYNC_EN inserts a two-flop
// synchronizer per channel ahead of the input register.
module phase_delay_multi
    import phase_delay_pkg::*;
#(
    parameter int N_CH       = N_CH_DEFAULT,
    parameter int EDGE_DEPTH = EDGE_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [N_CH-1:0]               sigIn,
    input  logic [N_CH*WAIT_CNT_SIZE-1:0] waitCnt,
    input  logic                          load,
    output logic [N_CH-1:0]               sigOut,
    output logic [N_CH-1:0]               overflow
);

    wait_t           t;
    wait_t           delay [N_CH];
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] s_prev;
    logic [N_CH-1:0] s_src;

`ifdef PHASE_DELAY_SYNC_EN
    logic [N_CH-1:0] sync_a;
    logic [N_CH-1:0] sync_b;

    // Two-flop synchronizer for comparator outputs not related to clk.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= sigIn;
            sync_b <= sync_a;
        end
    end

    assign s_src = sync_b;
`else
    assign s_src = sigIn;
`endif

    // Free-running timestamp shared by every channel; wraps modulo 2^W.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) t <= '0;
        else       t <= t + 1'b1;
    end

    // Input sample plus previous sample for edge detection.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s      <= '0;
            s_prev <= '0;
        end else begin
            s      <= s_src;
            s_prev <= s;
        end
    end

    // Shadow delay registers, changed only by a load strobe.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int c = 0; c < N_CH; c++) delay[c] <= '0;
        end else if (load) begin
            for (int c = 0; c < N_CH; c++) delay[c] <= waitCnt[c*WAIT_CNT_SIZE +: WAIT_CNT_SIZE];
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic        edge_seen;
        logic        q_pop;
        logic        q_level;
        logic        q_full;
        logic        out_q;
        logic        ovf_q;
        edge_entry_t entry;

        assign edge_seen = s[c] ^ s_prev[c];
        assign entry     = '{due: t + eff_delay(delay[c]), level: s[c]};

        // Load doubles as flush, so an edge seen in the load cycle is not queued.
        delay_edge_queue #(
            .DEPTH (EDGE_DEPTH)
        ) u_queue (
            .clk        (clk),
            .rstN       (rstN),
            .flush      (load),
            .push       (edge_seen),
            .push_entry (entry),
            .t          (t),
            .pop        (q_pop),
            .head_level (q_level),
            .full       (q_full)
        );

        // Output level follows popped events; load resynchronises it to s and clears overflow.
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                out_q <= 1'b0;
                ovf_q <= 1'b0;
            end else if (load) begin
                out_q <= s[c];
                ovf_q <= 1'b0;
            end else begin
                if (q_pop)              out_q <= q_level;
                if (edge_seen && q_full) ovf_q <= 1'b1;
            end
        end

        assign sigOut[c]   = out_q;
        assign overflow[c] = ovf_q;
    end

endmodule

// File: tb/tb_phase_delay_multi.sv
// tb_phase_delay_multi: directed bench for phase_delay_multi with an
// absolute-time event model compared every cycle, plus literal latency,
// overflow, reload and reset expectations.
module tb_phase_delay_multi;

    localparam int N_CH  = 4;
    localparam int W     = 11;
    localparam int DEPTH = 8;
`ifdef PHASE_DELAY_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif

    logic              clk     = 1'b0;
    logic              rstN    = 1'b0;
    logic [N_CH-1:0]   sigIn   = '0;
    logic [N_CH*W-1:0] waitCnt = '0;
    logic              load    = 1'b0;
    logic [N_CH-1:0]   sigOut;
    logic [N_CH-1:0]   overflow;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];

    // Clock.
    always #5 clk = ~clk;

    phase_delay_multi dut (
        .clk      (clk),
        .rstN     (rstN),
        .sigIn    (sigIn),
        .waitCnt  (waitCnt),
        .load     (load),
        .sigOut   (sigOut),
        .overflow (overflow)
    );

    // Model state: events carry absolute cycle numbers, no modular timestamp.
    int              n_now = 0;
    logic [N_CH-1:0] m_out = '0;
    logic [N_CH-1:0] m_ovf = '0;
    logic [N_CH-1:0] m_s   = '0;
    logic [N_CH-1:0] m_prev = '0;
    logic [N_CH-1:0] m_sy1 = '0;
    logic [N_CH-1:0] m_sy2 = '0;
    int              m_d [N_CH] = '{default: 0};
    int              due_q [N_CH][$];
    logic            lvl_q [N_CH][$];

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_out = '0; m_ovf = '0; m_s = '0; m_prev = '0; m_sy1 = '0; m_sy2 = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_d[c] = 0;
            due_q[c].delete();
            lvl_q[c].delete();
        end
    endtask

    task automatic model_step();
        n_now++;
        for (int c = 0; c < N_CH; c++) begin
            logic edge_seen;
            logic was_full;
            edge_seen = (m_s[c] != m_prev[c]);
            was_full  = (due_q[c].size() == DEPTH);
            if (load) begin
                m_out[c] = m_s[c];
                m_ovf[c] = 1'b0;
                due_q[c].delete();
                lvl_q[c].delete();
            end else begin
                if (due_q[c].size() > 0 && due_q[c][0] == n_now) begin
                    m_out[c] = lvl_q[c].pop_front();
                    void'(due_q[c].pop_front());
                end
                if (edge_seen) begin
                    if (was_full) begin
                        m_ovf[c] = 1'b1;
                    end else begin
                        due_q[c].push_back(n_now + eff(m_d[c]));
                        lvl_q[c].push_back(m_s[c]);
                    end
                end
            end
        end
        if (load) for (int c = 0; c < N_CH; c++) m_d[c] = int'(waitCnt[c*W +: W]);
        m_prev = m_s;
`ifdef PHASE_DELAY_SYNC_EN
        m_s   = m_sy2;
        m_sy2 = m_sy1;
        m_sy1 = sigIn;
`else
        m_s = sigIn;
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) model_reset();
            else       model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then compare the DUT against the model.
    task automatic tick();
        @(negedge clk);
        if (rstN) begin
            check("model_sigout", 32'(sigOut), 32'(m_out));
            check("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    endtask

    task automatic do_load(input int d0, input int d1, input int d2, input int d3);
        waitCnt = {W'(d3), W'(d2), W'(d1), W'(d0)};
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    // Flip one channel and count edges from the capturing edge to the output change.
    task automatic measure(input int ch, input int expected);
        logic lvl;
        int   k;
        bit   seen;
        exp_q.push_back((W+2)'(expected + SYNC_EXTRA));
        lvl       = ~sigIn[ch];
        sigIn[ch] = lvl;
        tick();
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 4000) begin
            tick();
            k++;
            if (sigOut[ch] == lvl) seen = 1'b1;
        end
        check($sformatf("latency_ch%0d", ch), 32'(k), 32'(exp_q.pop_front()));
    endtask

    int half [N_CH] = '{1, 3, 20, 300};

    initial begin
        // Reset.
        repeat (3) tick();
        rstN = 1'b1;
        check("reset_sigout", 32'(sigOut), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);

        // Delay 8: latency 9, then a period-64 square wave.
        do_load(8, 8, 8, 8);
        measure(0, 9);
        for (int i = 0; i < 256; i++) begin
            sigIn[0] = ((i / 32) % 2 == 1);
            tick();
        end
        sigIn[0] = 1'b0;
        repeat (20) tick();
        check("ovf_clean_sq64", 32'(overflow), 32'h0);

        // Four channels, four delays including the full-range 2047 (crosses t wrap).
        do_load(1, 4, 100, 2047);
        for (int i = 0; i < 2600; i++) begin
            for (int c = 0; c < N_CH; c++) sigIn[c] = ((i / half[c]) % 2 == 1);
            tick();
        end
        sigIn = '0;
        repeat (2100) tick();
        check("ovf_clean_multi", 32'(overflow), 32'h0);
        measure(3, 2048);
        measure(0, 2);
        measure(1, 5);
        measure(2, 101);

        // Zero delay behaves like one, and a one-cycle pulse is reproduced.
        do_load(0, 1, 4, 4);
        measure(0, 2);
        measure(1, 2);
        sigIn[0] = 1'b1;
        tick();
        sigIn[0] = 1'b0;
        tick();
        repeat (SYNC_EXTRA) tick();
        tick();
        check("pulse_high", 32'(sigOut[0]), 32'h1);
        tick();
        check("pulse_low", 32'(sigOut[0]), 32'h0);
        repeat (4) tick();

        // Overflow: 20 single-cycle toggles into a depth-8 queue with delay 200.
        do_load(200, 1, 4, 4);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            sigIn[0] = ~sigIn[0];
            tick();
        end
        tick();
        repeat (SYNC_EXTRA) tick();
        check("ovf_after_8_edges", 32'(overflow[0]), 32'h0);
        sigIn[0] = ~sigIn[0];
        tick();
        tick();
        repeat (SYNC_EXTRA) tick();
        check("ovf_after_9_edges", 32'(overflow[0]), 32'h1);
        for (int i = 0; i < 11; i++) begin
            sigIn[0] = ~sigIn[0];
            tick();
        end
        repeat (210) tick();
        check("ovf_final_level", 32'(sigOut[0]), 32'h0);
        check("ovf_sticky", 32'(overflow[0]), 32'h1);

        // Reload with an edge pending: flush, resync to s, clear overflow, new latency.
        sigIn[0] = 1'b1;
        repeat (3) tick();
        repeat (SYNC_EXTRA) tick();
        do_load(3, 1, 4, 4);
        check("reload_sigout", 32'(sigOut[0]), 32'h1);
        check("reload_overflow", 32'(overflow), 32'h0);
        repeat (10) tick();
        measure(0, 4);

        // Mid-stream reset with an output high and an overflow flagged.
        do_load(3, 200, 4, 4);
        sigIn[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sigIn[1] = ~sigIn[1];
            tick();
        end
        repeat (2 + SYNC_EXTRA) tick();
        check("pre_reset_ovf", 32'(overflow[1]), 32'h1);
        check("pre_reset_out", 32'(sigOut[0]), 32'h1);
        #2;
        rstN = 1'b0;
        #1;
        check("async_reset_sigout", 32'(sigOut), 32'h0);
        check("async_reset_overflow", 32'(overflow), 32'h0);
        repeat (2) tick();
        rstN = 1'b1;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_delay_multi.md
# phase_delay_multi

Multi-channel programmable digital delay line for the phase delay board. Each of N_CH logic-level channels is reproduced at its output delayed by an individually programmed number of clock cycles. Programmed delays may exceed the signal's half-period: edges are queued as timestamped events rather than held in a shift register. The block sits between the input comparators and the output drivers and replaces the single-channel fixed-window delay.

## Interface
- N_CH, 4, number of independent channels
- WAIT_CNT_SIZE, 11, delay word width in bits; maximum delay 2^WAIT_CNT_SIZE-1 cycles
- EDGE_DEPTH, 8, pending-edge queue depth per channel (power of two, >=2)

- clk  input  1  system clock; all logic on rising edge
- rstN  input  1  asynchronous active-low reset
- sigIn  input  N_CH  channel input levels, bit c = channel c
- waitCnt  input  N_CH*WAIT_CNT_SIZE  requested delays; channel c occupies bits [c*W +: W]
- load  input  1  one-cycle strobe: apply waitCnt to all channels
- sigOut  output  N_CH  delayed channel levels, registered
- overflow  output  N_CH  sticky per-channel flag: an edge was dropped

## Operation
- Free-running time counter t, WAIT_CNT_SIZE bits, wraps modulo 2^W; shared by all channels.
- Per channel: input register s, previous sample sPrev, active delay register D (shadow of waitCnt), edge queue of EDGE_DEPTH entries {due[W-1:0], level}.
- Edge detect: s != sPrev pushes {due = t + Deff (mod 2^W), level = s}; Deff = max(D,1), so D=0 behaves as D=1.
- Pop: when queue non-empty and head.due == t, sigOut[c] <= head.level and head is popped. Push and pop in the same cycle are both honoured.
- Queue full and new edge: edge discarded, overflow[c] set. Storing the level instead of a toggle makes sigOut self-correct at the next popped entry; no permanent inversion.
- load: every channel's D <= its waitCnt slice. All queues are flushed. sigOut[c] <= s[c]. overflow cleared. An edge detected in the load cycle is not queued.
- Delays stay constant between loads, so dues within a queue are monotonic in time and the head is always the earliest event.
- Reset values: sigOut=0, overflow=0, D=0 (effective 1), queues empty, t=0, s=sPrev=0.

## Timing
- Latency: sigOut[c] takes a new level exactly Deff+1 rising edges after the edge that first captures that level in s. Timing is independent per channel.
- Minimum resolvable pulse: 1 cycle; one-cycle pulses are reproduced exactly when the queue has space.
- Sustained edge rate per channel must not exceed EDGE_DEPTH edges per Deff cycles; beyond that, overflow.
- Wrap-around: due computation and compare are modulo 2^W. Max delay 2^W-1 never aliases with the current t.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Pending edges are lost.
- load coincident with a pop: load wins, and the pop is discarded by the flush.

## Configuration
- PHASE_DELAY_SYNC_EN defined: sigIn passes through a two-flop synchronizer before s; latency becomes Deff+3 edges from the first synchronizer flop sampling the new level.
- Undefined: sigIn is registered directly into s (single flop); latency as in Timing. Use only when sigIn is already synchronous to clk.

## Structure
- Package phase_delay_pkg: default parameter constants, queue entry struct {due, level}, function computing Deff with the 0->1 clamp.
- Sub-module delay_edge_queue: one per channel, generated N_CH times. Contains the FIFO with full/empty, push/pop/flush and the head compare against t. The top holds t, the shadow delays, input registers and load control.

## Test plan
- Single channel, load waitCnt=8, square wave period 64 on sigIn[0] -> sigOut[0] is the same wave shifted by 9 cycles; overflow=0.
- Channels 0..3 loaded with 1, 4, 100, 2047, each driven by a different square wave -> each output shifted by Deff+1; 2047 case crosses the t wrap cleanly.
- waitCnt=0 on one channel -> behaves identically to waitCnt=1 (2-cycle latency).
- EDGE_DEPTH=8, delay 200, 1-cycle-period toggling for 20 cycles -> overflow set after the 9th edge; sigOut ends at the correct final level after the queue drains.
- Reload 8->3 while edges are pending -> queues flushed, sigOut equals current s the next cycle, overflow cleared, then new latency 4.
- rstN pulsed low mid-stream -> sigOut and overflow go 0 immediately. With PHASE_DELAY_SYNC_EN, latency for delay 8 measures 11.
